// File: rtl/uart_tx.sv
// UART serial transmitter: start bit, LSB-first data, optional even parity, stop bit(s).
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx #(
  parameter int DATA_BITS     = 8,
  parameter int TICKS_PER_BIT = 16,
  parameter int STOP_BITS     = 1
) (
  input  logic                 clock,
  input  logic                 nreset,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int TICK_W = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
  localparam int BIT_W  = 4;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [TICK_W-1:0]    r_tick_cnt;
  logic [TICK_W-1:0]    w_tick_cnt_next;
  logic [BIT_W-1:0]     r_bit_cnt;
  logic [BIT_W-1:0]     w_bit_cnt_next;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_next;
  logic                 r_tx;
  logic                 w_tx_next;
  logic                 w_accept;
  logic                 w_bit_end;
  logic                 w_last_data;
  logic                 w_last_stop;
`ifdef UART_TX_PARITY_EN
  logic                 r_parity;
`endif

  assign w_accept    = (r_state == S_IDLE) && tx_valid;
  assign w_bit_end   = (r_state != S_IDLE) && baud_tick && (r_tick_cnt == TICK_LAST);
  assign w_last_data = (r_bit_cnt == DATA_LAST);
  assign w_last_stop = (r_bit_cnt == STOP_LAST);

  // State register
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: every transition out of a busy state happens on a bit boundary
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_next = S_START;
      end
      S_START: begin
        if (w_bit_end) w_state_next = S_DATA;
      end
      S_DATA: begin
        if (w_bit_end && w_last_data) begin
`ifdef UART_TX_PARITY_EN
          w_state_next = S_PARITY;
`else
          w_state_next = S_STOP;
`endif
        end
      end
      S_PARITY: begin
        if (w_bit_end) w_state_next = S_STOP;
      end
      S_STOP: begin
        if (w_bit_end && w_last_stop) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output decode; tx_done is the final stop boundary itself, so ready follows one cycle later
  always_comb begin
    tx_ready = (r_state == S_IDLE);
    tx_busy  = (r_state != S_IDLE);
    tx_done  = (r_state == S_STOP) && w_bit_end && w_last_stop;
    tx       = r_tx;
  end

  // Counters and shifter; a tick arriving on the accept edge is discarded
  always_comb begin
    w_tick_cnt_next = r_tick_cnt;
    w_bit_cnt_next  = r_bit_cnt;
    w_shift_next    = r_shift;
    if (r_state == S_IDLE) begin
      w_tick_cnt_next = '0;
      w_bit_cnt_next  = '0;
      if (w_accept) w_shift_next = tx_data;
    end else if (baud_tick) begin
      if (w_bit_end) begin
        w_tick_cnt_next = '0;
        w_bit_cnt_next  = (w_state_next == r_state) ? r_bit_cnt + 1'b1 : '0;
        if (r_state == S_DATA) w_shift_next = r_shift >> 1;
      end else begin
        w_tick_cnt_next = r_tick_cnt + 1'b1;
      end
    end
  end

  // The line level is computed from the state being entered so tx is a clean register output
  always_comb begin
    w_tx_next = 1'b1;
    unique case (w_state_next)
      S_START:  w_tx_next = 1'b0;
      S_DATA:   w_tx_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: w_tx_next = r_parity;
`endif
      default:  w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
    end else begin
      r_tick_cnt <= w_tick_cnt_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_shift    <= w_shift_next;
      r_tx       <= w_tx_next;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_parity <= 1'b0;
    end else if (w_accept) begin
      r_parity <= ^tx_data;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed steps, scoreboard of expected frames,
// line monitor decoding frames by counting baud ticks.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FB     = 1 + 8 + P + 1;
  localparam int FRAME  = FB * 160;
  localparam int FRAME2 = (FB + 1) * 160;

  typedef struct {
    logic [7:0] d;
    int         clks;
  } exp_t;

  logic       clock;
  logic       nreset = 1'b1;
  logic       baud_tick;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, tx, tx_busy, tx_done;
  logic [7:0] tx_data2;
  logic       tx_valid2;
  logic       tx_ready2, tx2, tx_busy2, tx_done2;
  logic       gap = 1'b0;
  int         tc;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t sb[$];
  exp_t e;

  logic        m_busy = 1'b0;
  int          m_ticks, m_clks, m_nb, m_idle, m_last_idle, m_starts, done_cnt;
  logic [15:0] m_bits;
  logic        m_rdy_bad;
  int          run2, stop_run2, done2_cnt;

  uart_tx #(.DATA_BITS(8), .TICKS_PER_BIT(16), .STOP_BITS(1)) u_dut (
    .clock(clock), .nreset(nreset), .baud_tick(baud_tick), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  uart_tx #(.DATA_BITS(8), .TICKS_PER_BIT(16), .STOP_BITS(2)) u_dut2 (
    .clock(clock), .nreset(nreset), .baud_tick(baud_tick), .tx_data(tx_data2),
    .tx_valid(tx_valid2), .tx_ready(tx_ready2), .tx(tx2), .tx_busy(tx_busy2), .tx_done(tx_done2)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Divider model: one tick every 10 clocks; gap freezes its phase
  initial begin
    tc = 0;
    baud_tick = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (!gap) tc = (tc == 9) ? 0 : tc + 1;
      baud_tick = !gap && (tc == 9);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, required finish before 50000 cycles");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_bits(input logic [7:0] d);
    logic [15:0] b;
    b = '0;
    for (int i = 0; i < 8; i++) b[1+i] = d[i];
`ifdef UART_TX_PARITY_EN
    b[9]  = ^d;
    b[10] = 1'b1;
`else
    b[9]  = 1'b1;
`endif
    return b;
  endfunction

  // Line monitor: sample each bit after 8 of its 16 ticks
  always @(negedge clock) begin
    if (!nreset) begin
      m_busy = 1'b0;
      m_idle = 0;
      run2   = 0;
    end else begin
      if (tx_done) done_cnt++;
      if (!m_busy) begin
        if (tx === 1'b0) begin
          m_busy      = 1'b1;
          m_ticks     = 0;
          m_clks      = 0;
          m_nb        = 0;
          m_bits      = '0;
          m_rdy_bad   = 1'b0;
          m_last_idle = m_idle;
          m_starts++;
        end else begin
          m_idle++;
        end
      end
      if (m_busy) begin
        m_clks++;
        if (tx_ready !== 1'b0) m_rdy_bad = 1'b1;
        if (m_nb < FB && m_ticks == 16 * m_nb + 8) begin
          m_bits[m_nb] = tx;
          m_nb++;
        end
        if (baud_tick) m_ticks++;
        if (tx_done) begin
          chk("sb_nonempty", sb.size() > 0, 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("frame_bits", m_bits, exp_bits(e.d));
            chk("frame_ticks", m_ticks, FB * 16);
            chk("frame_clks", m_clks, e.clks);
            chk("ready_low_in_frame", m_rdy_bad, 0);
          end
          m_busy = 1'b0;
          m_idle = 0;
        end
      end
      if (tx_busy2 && tx2) run2++;
      else run2 = 0;
      if (tx_done2) begin
        stop_run2 = run2;
        done2_cnt++;
        run2 = 0;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic align();
    int n;
    n = 0;
    while (baud_tick !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("align_tick", baud_tick, 1);
  endtask

  task automatic send_aligned(input logic [7:0] d, input int clks);
    align();
    tx_data  = d;
    tx_valid = 1'b1;
    sb.push_back('{d, clks});
    step();
    tx_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (tx_done !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    chk(tag, tx_done, 1);
  endtask

  initial begin
    int d0, f0;
    done_cnt = 0; m_starts = 0; m_idle = 0; done2_cnt = 0; run2 = 0; stop_run2 = 0;
    tx_data = 8'h00; tx_valid = 1'b0; tx_data2 = 8'h00; tx_valid2 = 1'b0;
    nreset = 1'b0;
    repeat (3) step();
    chk("rst_tx", tx, 1);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_done", tx_done, 0);
    nreset = 1'b1;
    repeat (3) step();

    // Single frame 0xA5
    d0 = done_cnt;
    send_aligned(8'hA5, FRAME);
    chk("accept_tx", tx, 0);
    chk("accept_busy", tx_busy, 1);
    chk("accept_ready", tx_ready, 0);
    wait_done("a5_done", FRAME + 100);
    chk("ready_at_done", tx_ready, 0);
    step();
    chk("ready_after_done", tx_ready, 1);
    chk("idle_tx", tx, 1);
    chk("a5_done_count", done_cnt - d0, 1);

    // Parity patterns (odd and even number of ones)
    send_aligned(8'hA5, FRAME);
    wait_done("a5b_done", FRAME + 100);
    step();
    send_aligned(8'h07, FRAME);
    wait_done("07_done", FRAME + 100);
    step();

    // Back-to-back with tx_valid held; data changes after accept must not reach the line
    d0 = done_cnt;
    align();
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    sb.push_back('{8'h00, FRAME});
    sb.push_back('{8'hFF, FRAME - 1});
    step();
    tx_data = 8'hFF;
    wait_done("b2b_first_done", FRAME + 100);
    step();
    chk("b2b_idle_ready", tx_ready, 1);
    step();
    chk("b2b_second_busy", tx_busy, 1);
    tx_valid = 1'b0;
    repeat (400) step();
    tx_data = 8'h3C;
    wait_done("b2b_second_done", FRAME + 100);
    step();
    chk("b2b_done_count", done_cnt - d0, 2);
    chk("b2b_idle_gap", m_last_idle, 1);
    repeat (5) step();

    // Reset during data bit 3 of 0x55
    d0 = done_cnt;
    send_aligned(8'h55, FRAME);
    repeat (700) step();
    chk("pre_rst_tx", tx, 0);
    nreset = 1'b0;
    #1;
    chk("rst_async_tx", tx, 1);
    chk("rst_async_ready", tx_ready, 1);
    chk("rst_async_busy", tx_busy, 0);
    void'(sb.pop_back());
    repeat (3) step();
    nreset = 1'b1;
    step();
    chk("rst_no_done", done_cnt - d0, 0);
    chk("rst_release_ready", tx_ready, 1);
    send_aligned(8'h81, FRAME);
    wait_done("81_done", FRAME + 100);
    step();

    // 500-clock tick gap inside the start bit
    send_aligned(8'hC3, FRAME + 500);
    repeat (50) step();
    gap = 1'b1;
    repeat (500) step();
    gap = 1'b0;
    wait_done("gap_done", FRAME + 100);
    step();

    // tx_valid pulsed while busy is dropped
    f0 = m_starts;
    send_aligned(8'h5A, FRAME);
    repeat (300) step();
    tx_data  = 8'h99;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    chk("ign_busy", tx_busy, 1);
    wait_done("ign_done", FRAME + 100);
    step();
    repeat (300) step();
    chk("ign_frames", m_starts - f0, 1);
    chk("ign_sb_empty", sb.size(), 0);
    chk("ign_idle_tx", tx, 1);
    chk("ign_idle_ready", tx_ready, 1);

    // Two stop bits on the second instance
    align();
    tx_data2  = 8'h00;
    tx_valid2 = 1'b1;
    step();
    tx_valid2 = 1'b0;
    chk("s2_busy", tx_busy2, 1);
    begin
      int n;
      n = 0;
      while (tx_done2 !== 1'b1 && n < FRAME2 + 100) begin
        step();
        n++;
      end
    end
    chk("s2_done_seen", tx_done2, 1);
    step();
    chk("s2_stop_len", stop_run2, 320);
    chk("s2_done_count", done2_cnt, 1);
    chk("s2_ready", tx_ready2, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART serial transmitter that consumes the divided reference-rate tick produced by the clock-divider stage and serialises parallel bytes onto the tx line. It sits directly downstream of the reference-clock divider and upstream of the pad. All logic runs on the single system clock. The divider output enters as a one-cycle `baud_tick` enable, not as a clock. Frame format: start bit, LSB-first data, optional parity, stop bit(s).

Parameters:
- DATA_BITS, 8, data bits per frame (5..9).
- TICKS_PER_BIT, 16, baud_tick pulses per serial bit (≥1).
- STOP_BITS, 1, stop bits per frame (1 or 2).

Ports:
- clock  in  1  system clock, all state on rising edge.
- nreset  in  1  asynchronous active-low reset.
- baud_tick  in  1  one-clock-wide enable pulse from the divider stage; at most one per clock.
- tx_data  in  DATA_BITS  byte to send; sampled only on accept.
- tx_valid  in  1  producer has data.
- tx_ready  out  1  block can accept; decoded from state == IDLE.
- tx  out  1  serial line, idle high.
- tx_busy  out  1  frame in progress; equals ~tx_ready.
- tx_done  out  1  one-cycle pulse at end of last stop bit.

Behaviour:
- Clock and reset:
  - Single clock domain. Reset is asynchronous and active-low.
  - While nreset=0: tx=1, tx_ready=1, tx_busy=0, tx_done=0, state=IDLE, tick counter=0, bit counter=0, shift register=0.
- States: IDLE → START → DATA → [PARITY] → STOP → IDLE.
- Accept (handshake):
  - Occurs on a rising edge with tx_valid=1 and tx_ready=1.
  - tx_data is latched into the shift register, tick counter and bit counter clear, state goes to START.
  - tx drives 0 from the next cycle.
  - tx_data changes after accept have no effect.
  - tx_valid while busy is ignored; no queuing.
- Tick counter:
  - Counts baud_tick pulses 0..TICKS_PER_BIT-1 while busy.
  - A bit boundary occurs on a clock where baud_tick=1 and count=TICKS_PER_BIT-1. The counter then wraps to 0 and the state/bit advances on that edge.
  - Each bit therefore lasts exactly TICKS_PER_BIT ticks. Gaps in baud_tick stretch the bit; clock cycles without a tick change nothing.
  - In IDLE the counter is held at 0 and baud_tick is ignored, so the start bit is measured from the first tick after accept.
- Bit sequence:
  - START: tx=0.
  - DATA: tx = shift register LSB. Shift right at each boundary; bit counter runs 0..DATA_BITS-1.
  - STOP: tx=1. Bit counter runs 0..STOP_BITS-1.
- Frame length = (1 + DATA_BITS + P + STOP_BITS) × TICKS_PER_BIT ticks, where P=1 with the parity feature, else 0.
- tx is registered; no glitches between bits.
- End of frame:
  - At the final STOP boundary: tx_done=1 for that single cycle, state→IDLE, tx_ready=1 from the next cycle.
  - Back-to-back: with tx_valid held high, the next accept occurs on the first cycle tx_ready=1. No extra idle bit is inserted beyond the stop bit(s).
- Reset mid-frame: tx returns to 1 immediately (asynchronously). The frame is abandoned, no tx_done pulse, and after release the block is in IDLE ready to accept.
- Simultaneous events: accept and baud_tick on the same edge → the tick is not counted toward the start bit.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP, lasting TICKS_PER_BIT ticks.
  - tx = even parity (XOR of the latched DATA_BITS data bits), computed at accept and held in a register.
- Undefined: DATA goes directly to STOP; no parity register exists.

Test Plan:
- Common setup: DATA_BITS=8, TICKS_PER_BIT=16, STOP_BITS=1, baud_tick every 10 clocks. This gives 160 clocks per bit.
- Single frame 0xA5, no parity:
  - Stimulus: one accept.
  - Required: tx = 0,1,0,1,0,0,1,0,1,1, each bit 160 clocks, 1600 clocks total.
  - One tx_done pulse. tx_ready low throughout, high the cycle after tx_done.
- Parity build, 0xA5 then 0x07:
  - 0xA5 (four ones): parity bit 0, 11-bit frame, 1760 clocks.
  - 0x07 (three ones): parity bit 1.
- Back-to-back 0x00 then 0xFF, tx_valid held high:
  - Second start bit begins immediately after the first stop bit; no gap longer than one clock.
  - Exactly two tx_done pulses. tx_data changed to 0x3C mid-frame has no effect on the line.
- Reset mid-frame:
  - Stimulus: assert nreset during data bit 3 of 0x55.
  - Required: tx=1 within the same cycle, no tx_done. A new frame 0x81 after release is transmitted correctly.
- Tick gaps:
  - Stimulus: hold baud_tick low for 500 clocks during the start bit.
  - Required: the start bit stretches by exactly 500 clocks and the rest of the frame is unchanged.
  - With STOP_BITS=2: the stop level lasts 320 clocks before tx_done.
- Busy ignore:
  - Stimulus: tx_valid pulses while tx_busy=1.
  - Required: no accept, the frame in progress is unaffected, and the pulsed data is never sent.
